// File: rtl/router_rx_port.sv
// Receive side of a router output port: pulls a packet from the port FIFO, re-times it
// through an output register plus a one-entry skid buffer, and reports per-packet status.
// Optional statistics counters (pkt_cnt, err_cnt) are built when ROUTER_RX_STATS_EN is defined.

module router_rx_port #(
    parameter logic [1:0]  PORT_ID    = 2'd0,
    parameter int unsigned WAIT_LIMIT = 30
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        valid_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    input  logic        sink_ready,
    output logic [7:0]  byte_out,
    output logic        byte_vld,
    output logic        byte_first,
    output logic        byte_last,
    output logic        pkt_done,
    output logic        parity_err,
    output logic        addr_err,
`ifdef ROUTER_RX_STATS_EN
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt,
`endif
    output logic        starve_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [7:0] STARVE_MAX = 8'(WAIT_LIMIT - 1);

    function automatic logic [6:0] hdr_total(input logic [7:0] hdr);
        return {1'b0, hdr[7:2]} + 7'd2;
    endfunction

    state_e     state_q, state_d;
    logic [6:0] issued_q, issued_d;
    logic [6:0] received_q, received_d;
    logic [6:0] total_q, total_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] xor_q, xor_d;
    logic [7:0] starve_q, starve_d;
    logic       pend_q, pend_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_vld_q, out_vld_d;
    logic       out_first_q, out_first_d;
    logic       out_last_q, out_last_d;
    logic [7:0] skid_data_q, skid_data_d;
    logic       skid_vld_q, skid_vld_d;
    logic       skid_first_q, skid_first_d;
    logic       skid_last_q, skid_last_d;
    logic       done_q, done_d;
    logic       perr_q, perr_d;
    logic       aerr_q, aerr_d;
    logic       serr_q, serr_d;

    logic hdr_seen_s;
    logic rd_room_s;
    logic read_enb_s;
    logic arr_first_s;
    logic arr_last_s;
    logic xfer_s;
    logic out_free_s;
    logic short_s;
    logic starve_tick_s;
    logic abort_s;

    // Before the header lands only two reads are safe, since every packet has at least two bytes.
    assign hdr_seen_s    = (received_q != 7'd0);
    assign rd_room_s     = hdr_seen_s ? (issued_q < total_q) : (issued_q < 7'd2);
    assign read_enb_s    = (state_q == ST_RECV) & valid_out & sink_ready & ~skid_vld_q & rd_room_s;
    assign arr_first_s   = pend_q & ~hdr_seen_s;
    assign arr_last_s    = pend_q & hdr_seen_s & ((received_q + 7'd1) == total_q);
    assign xfer_s        = out_vld_q & sink_ready;
    assign out_free_s    = ~out_vld_q | xfer_s;
    assign short_s       = ~hdr_seen_s | (received_q < total_q);
    assign starve_tick_s = (state_q == ST_RECV) & ~read_enb_s & short_s;
    assign abort_s       = starve_tick_s & (starve_q == STARVE_MAX);

    assign read_enb   = read_enb_s;
    assign byte_out   = out_data_q;
    assign byte_vld   = out_vld_q;
    assign byte_first = out_first_q;
    assign byte_last  = out_last_q;
    assign pkt_done   = done_q;
    assign parity_err = perr_q;
    assign addr_err   = aerr_q;
    assign starve_err = serr_q;

    // Next-state logic for the FSM, packet counters, output register and skid entry.
    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        received_d   = received_q;
        total_d      = total_q;
        addr_d       = addr_q;
        xor_d        = xor_q;
        starve_d     = starve_q;
        pend_d       = read_enb_s;
        out_data_d   = out_data_q;
        out_vld_d    = out_vld_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        skid_data_d  = skid_data_q;
        skid_vld_d   = skid_vld_q;
        skid_first_d = skid_first_q;
        skid_last_d  = skid_last_q;
        done_d       = 1'b0;
        perr_d       = 1'b0;
        aerr_d       = 1'b0;
        serr_d       = 1'b0;

        if (read_enb_s) begin
            issued_d = issued_q + 7'd1;
        end else begin
            issued_d = issued_q;
        end

        if (pend_q) begin
            received_d = received_q + 7'd1;
            xor_d      = xor_q ^ data_out;
            if (arr_first_s) begin
                total_d = hdr_total(data_out);
                addr_d  = data_out[1:0];
            end else begin
                total_d = total_q;
                addr_d  = addr_q;
            end
        end else begin
            received_d = received_q;
            xor_d      = xor_q;
        end

        if (read_enb_s) begin
            starve_d = 8'd0;
        end else if (starve_tick_s) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end

        // A held skid byte always moves ahead of a newly arriving byte to preserve order.
        if (skid_vld_q && out_free_s) begin
            out_data_d   = skid_data_q;
            out_vld_d    = 1'b1;
            out_first_d  = skid_first_q;
            out_last_d   = skid_last_q;
            skid_vld_d   = pend_q;
            skid_data_d  = data_out;
            skid_first_d = arr_first_s;
            skid_last_d  = arr_last_s;
        end else if (pend_q && out_free_s) begin
            out_data_d  = data_out;
            out_vld_d   = 1'b1;
            out_first_d = arr_first_s;
            out_last_d  = arr_last_s;
        end else if (pend_q) begin
            skid_vld_d   = 1'b1;
            skid_data_d  = data_out;
            skid_first_d = arr_first_s;
            skid_last_d  = arr_last_s;
        end else if (xfer_s) begin
            out_vld_d   = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            out_vld_d  = out_vld_q;
            skid_vld_d = skid_vld_q;
        end

        case (state_q)
            ST_IDLE: begin
                issued_d   = 7'd0;
                received_d = 7'd0;
                xor_d      = 8'd0;
                starve_d   = 8'd0;
                pend_d     = 1'b0;
                if (valid_out) begin
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                // Abort flushes everything in flight; parity is meaningless for a partial packet.
                if (abort_s) begin
                    state_d      = ST_IDLE;
                    done_d       = 1'b1;
                    serr_d       = 1'b1;
                    aerr_d       = hdr_seen_s & (addr_q != PORT_ID);
                    pend_d       = 1'b0;
                    out_vld_d    = 1'b0;
                    out_first_d  = 1'b0;
                    out_last_d   = 1'b0;
                    skid_vld_d   = 1'b0;
                    skid_first_d = 1'b0;
                    skid_last_d  = 1'b0;
                end else if (arr_last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && out_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    perr_d  = (xor_q != 8'd0);
                    aerr_d  = (addr_q != PORT_ID);
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                out_vld_d  = 1'b0;
                skid_vld_d = 1'b0;
            end
        endcase
    end

    // State, datapath and status registers.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q      <= ST_IDLE;
            issued_q     <= 7'd0;
            received_q   <= 7'd0;
            total_q      <= 7'd0;
            addr_q       <= 2'd0;
            xor_q        <= 8'd0;
            starve_q     <= 8'd0;
            pend_q       <= 1'b0;
            out_data_q   <= 8'd0;
            out_vld_q    <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            skid_data_q  <= 8'd0;
            skid_vld_q   <= 1'b0;
            skid_first_q <= 1'b0;
            skid_last_q  <= 1'b0;
            done_q       <= 1'b0;
            perr_q       <= 1'b0;
            aerr_q       <= 1'b0;
            serr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            total_q      <= total_d;
            addr_q       <= addr_d;
            xor_q        <= xor_d;
            starve_q     <= starve_d;
            pend_q       <= pend_d;
            out_data_q   <= out_data_d;
            out_vld_q    <= out_vld_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            skid_data_q  <= skid_data_d;
            skid_vld_q   <= skid_vld_d;
            skid_first_q <= skid_first_d;
            skid_last_q  <= skid_last_d;
            done_q       <= done_d;
            perr_q       <= perr_d;
            aerr_q       <= aerr_d;
            serr_q       <= serr_d;
        end
    end

`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;

    // Saturating packet and error counters, stepped once per pkt_done pulse.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            pkt_cnt_q <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            if (done_q && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end else begin
                pkt_cnt_q <= pkt_cnt_q;
            end
            if (done_q && (perr_q || aerr_q || serr_q) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
                err_cnt_q <= err_cnt_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_rx_port.sv
// Randomized self-checking bench for router_rx_port: a queue-based FIFO feeds packets and a
// packet-level model predicts the byte stream, read counts and per-packet status.

module tb_router_rx_port;

    localparam logic [1:0] PORT = 2'd1;
    localparam int         WL   = 30;

    logic       clock = 1'b0;
    logic       resetn;
    logic       valid_out;
    logic [7:0] data_out;
    logic       read_enb;
    logic       sink_ready;
    logic [7:0] byte_out;
    logic       byte_vld;
    logic       byte_first;
    logic       byte_last;
    logic       pkt_done;
    logic       parity_err;
    logic       addr_err;
    logic       starve_err;
`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
`endif

    router_rx_port #(.PORT_ID(PORT), .WAIT_LIMIT(WL)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .sink_ready (sink_ready),
        .byte_out   (byte_out),
        .byte_vld   (byte_vld),
        .byte_first (byte_first),
        .byte_last  (byte_last),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err),
`ifdef ROUTER_RX_STATS_EN
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt),
`endif
        .starve_err (starve_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic perr;
        logic aerr;
        logic serr;
        int   nrd;
    } res_t;

    logic [7:0] fifo_q[$];
    logic [9:0] exp_byte_q[$];
    res_t       res_q[$];
    logic [7:0] pkt_q[$];

    int total_cnt = 0;
    int bad_cnt   = 0;
    int step_n    = 0;
    int rd_cnt    = 0;
    int n_done    = 0;
    int n_err     = 0;
    int done_step = 0;
    int last_rd_step  = 0;
    int first_rd_step = -1;
    int sink_mode = 0;
    int gate_pct  = 100;
    logic       rd_prev = 1'b0;
    logic [7:0] rd_byte = 8'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic make_pkt(input int len, input logic [1:0] addr, input bit good);
        logic [7:0] x;
        pkt_q.delete();
        pkt_q.push_back({6'(len), addr});
        for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
        x = 8'd0;
        foreach (pkt_q[i]) x ^= pkt_q[i];
        pkt_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    // Feed the first n_feed bytes of pkt_q; a starved packet never completes normally.
    task automatic queue_pkt(input int n_feed, input bit starve);
        res_t       r;
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < n_feed; i++) begin
            fifo_q.push_back(pkt_q[i]);
            exp_byte_q.push_back({(i == 0), (!starve && (i == pkt_q.size() - 1)), pkt_q[i]});
            x ^= pkt_q[i];
        end
        r.perr = !starve && (x != 8'd0);
        r.aerr = (pkt_q[0][1:0] != PORT);
        r.serr = starve;
        r.nrd  = n_feed;
        if (r.perr || r.aerr || r.serr) n_err++;
        res_q.push_back(r);
    endtask

    // One clock: drive inputs at the falling edge, then observe settled outputs.
    task automatic step();
        res_t       r;
        logic [9:0] e;
        @(negedge clock);
        step_n++;
        data_out = rd_prev ? rd_byte : 8'($urandom);
        case (sink_mode)
            0:       sink_ready = 1'b1;
            1:       sink_ready = ~sink_ready;
            default: sink_ready = ($urandom_range(99) < 75);
        endcase
        valid_out = (fifo_q.size() > 0) && ($urandom_range(99) < gate_pct);
        #1;
        if (pkt_done) begin
            n_done++;
            done_step = step_n;
            if (res_q.size() == 0) begin
                chk("done_unexpected", 32'(pkt_done), 32'(0));
            end else begin
                r = res_q.pop_front();
                chk("parity_err", 32'(parity_err), 32'(r.perr));
                chk("addr_err", 32'(addr_err), 32'(r.aerr));
                chk("starve_err", 32'(starve_err), 32'(r.serr));
                chk("read_count", 32'(rd_cnt), 32'(r.nrd));
            end
            rd_cnt = 0;
        end else begin
            chk("err_no_done", 32'({parity_err, addr_err, starve_err}), 32'(0));
        end
        if (byte_vld && sink_ready) begin
            if (exp_byte_q.size() == 0) begin
                chk("xfer_extra", 32'(byte_vld), 32'(0));
            end else begin
                e = exp_byte_q.pop_front();
                chk("byte", 32'({byte_first, byte_last, byte_out}), 32'(e));
            end
        end
        chk("rd_no_data", 32'(read_enb & ~valid_out), 32'(0));
        rd_prev = read_enb;
        if (read_enb) begin
            rd_cnt++;
            last_rd_step = step_n;
            if (first_rd_step < 0) first_rd_step = step_n;
            if (fifo_q.size() > 0) rd_byte = fifo_q.pop_front();
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (n_done < target && n < budget) begin
            step();
            n++;
        end
        if (n_done < target) chk("timeout", 32'(n_done), 32'(target));
        chk("bytes_left", 32'(exp_byte_q.size()), 32'(0));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, 32'({read_enb, byte_vld, byte_first, byte_last, pkt_done,
                      parity_err, addr_err, starve_err, byte_out}), 32'(0));
    endtask

    int saved_done;
    int saved_err;
    int npk;
    int len;

    initial begin
        resetn     = 1'b1;
        valid_out  = 1'b0;
        data_out   = 8'd0;
        sink_ready = 1'b0;
        repeat (3) step();
        chk_outs_zero("reset_outs");
        resetn = 1'b0;
        repeat (2) step();

        // Reset in the middle of a packet discards it without a pkt_done.
        make_pkt(40, PORT, 1'b1);
        queue_pkt(pkt_q.size(), 1'b0);
        repeat (12) step();
        resetn = 1'b1;
        #1;
        chk_outs_zero("async_reset_outs");
        fifo_q.delete();
        exp_byte_q.delete();
        res_q.delete();
        rd_prev = 1'b0;
        rd_cnt  = 0;
        n_err   = 0;
        saved_done = n_done;
        repeat (3) step();
        resetn = 1'b0;
        repeat (8) step();
        chk("no_done_after_reset", 32'(n_done), 32'(saved_done));
        saved_err = n_err;

        // Header 0D: len 3, addr 1; E3 is the byte that makes the packet XOR to zero.
        pkt_q = {8'h0D, 8'hAA, 8'h55, 8'h11, 8'hE3};
        queue_pkt(pkt_q.size(), 1'b0);
        first_rd_step = -1;
        run_until(n_done + 1, 200);
        chk("consecutive_reads", 32'(last_rd_step - first_rd_step + 1), 32'(5));

        pkt_q = {8'h0D, 8'hAA, 8'h55, 8'h11, 8'h00};
        queue_pkt(pkt_q.size(), 1'b0);
        run_until(n_done + 1, 200);

        pkt_q = {8'h02, 8'h02};
        queue_pkt(pkt_q.size(), 1'b0);
        run_until(n_done + 1, 200);

        sink_mode = 1;
        make_pkt(63, PORT, 1'b1);
        queue_pkt(pkt_q.size(), 1'b0);
        run_until(n_done + 1, 1000);

        // Starve: header of a len-10 packet plus 3 payload bytes, then the FIFO runs dry.
        sink_mode = 0;
        make_pkt(10, PORT, 1'b1);
        queue_pkt(4, 1'b1);
        run_until(n_done + 1, 500);
        // Outputs seen at step n reflect the edge that closed step n-1.
        chk("starve_latency", 32'(done_step - last_rd_step), 32'(WL + 1));
        chk("abort_byte_vld", 32'(byte_vld), 32'(0));
        repeat (3) step();
        chk("abort_idle_reads", 32'(rd_cnt), 32'(0));

        for (int i = 0; i < 20; i++) begin
            sink_mode = $urandom_range(2);
            gate_pct  = ($urandom_range(1) == 1) ? 100 : 85;
            npk       = $urandom_range(1, 2);
            for (int k = 0; k < npk; k++) begin
                if ($urandom_range(3) == 0) len = ($urandom_range(1) == 1) ? 63 : 0;
                else                        len = $urandom_range(63);
                make_pkt(len, 2'($urandom_range(3)), $urandom_range(9) < 7);
                queue_pkt(pkt_q.size(), 1'b0);
            end
            run_until(n_done + npk, 2000);
            repeat ($urandom_range(3)) step();
        end

        repeat (3) step();
`ifdef ROUTER_RX_STATS_EN
        chk("pkt_cnt", 32'(pkt_cnt), 32'(n_done - saved_done));
        chk("err_cnt", 32'(err_cnt), 32'(n_err - saved_err));
`endif
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
